zynet_argmax_reader: RTL and testbench

ZYNET_ARGMAX_READER -- requirements
Module: zynet_argmax_reader

---
 rtl/zynet_pkg.sv | 18 +
 rtl/zynet_argmax_reader.sv | 102 ++++++++++
 tb/tb_zynet_argmax_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/zynet_pkg.sv
// Shared network constants and FSM state type for the zynet output stages.
`timescale 1ns/1ps
package zynet_pkg;

    localparam int NET_WORD_SIZE   = 16;
    localparam int NET_OUTPUT_SIZE = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zynet_argmax_reader.sv
// Sequential argmax over a registered score frame: one compare per cycle,
// result held until the downstream handshake.
`timescale 1ns/1ps
module zynet_argmax_reader
    import zynet_pkg::*;
#(
    parameter int WORD_SIZE   = NET_WORD_SIZE,
    parameter int OUTPUT_SIZE = NET_OUTPUT_SIZE,
    localparam int IDX_W      = idx_width(OUTPUT_SIZE)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] data_i,
    input  logic                                  valid_i,
    output logic                                  yumi_o,
    output logic [IDX_W-1:0]                      class_o,
    output logic [WORD_SIZE-1:0]                  score_o,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [7:0]                            frames_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    argmax_state_t state_q, state_d;

    logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] scores_q;
    logic signed [WORD_SIZE-1:0] best_q;
    logic signed [WORD_SIZE-1:0] cand;
    logic [IDX_W-1:0] best_idx_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0] frames_q;
    logic take;
    logic better;
    logic handshake;

    assign cand   = scores_q[idx_q];
    // Strict compare keeps the lowest index on ties.
    assign better = cand > best_q;

    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        handshake = 1'b0;
        unique case (state_q)
            IDLE: begin
                take = reset_i & valid_i;
                if (take) begin
                    state_d = (OUTPUT_SIZE == 1) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                handshake = ready_i;
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            scores_q   <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
            frames_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                scores_q   <= data_i;
                best_q     <= data_i[0];
                best_idx_q <= '0;
                idx_q      <= ONE_IDX;
            end else if (state_q == SCAN) begin
                if (better) begin
                    best_q     <= cand;
                    best_idx_q <= idx_q;
                end
                idx_q <= idx_q + ONE_IDX;
            end
            if (handshake) begin
                frames_q <= frames_q + 8'd1;
            end
        end
    end

    assign yumi_o   = take;
    assign valid_o  = (state_q == DONE);
    assign class_o  = best_idx_q;
    assign score_o  = best_q;
    assign frames_o = frames_q;

endmodule

// File: tb/tb_zynet_argmax_reader.sv
// Directed bench for zynet_argmax_reader: vector table plus handshake,
// reset-abort, wraparound and single-score corner sequences.
`timescale 1ns/1ps
module tb_zynet_argmax_reader;

    typedef logic [9:0][15:0] frame_t;

    typedef struct {
        frame_t      data;
        int          exp_class;
        logic [15:0] exp_score;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_i;
    frame_t      data_i;
    logic        valid_i;
    logic        yumi_o;
    logic [3:0]  class_o;
    logic [15:0] score_o;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  frames_o;

    logic [0:0][15:0] data1_i;
    logic        valid1_i;
    logic        yumi1_o;
    logic [0:0]  class1_o;
    logic [15:0] score1_o;
    logic        valid1_o;
    logic        ready1_i;
    logic [7:0]  frames1_o;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    zynet_argmax_reader dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i),
        .valid_i(valid_i), .yumi_o(yumi_o), .class_o(class_o),
        .score_o(score_o), .valid_o(valid_o), .ready_i(ready_i),
        .frames_o(frames_o)
    );

    zynet_argmax_reader #(.WORD_SIZE(16), .OUTPUT_SIZE(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data1_i),
        .valid_i(valid1_i), .yumi_o(yumi1_o), .class_o(class1_o),
        .score_o(score1_o), .valid_o(valid1_o), .ready_i(ready1_i),
        .frames_o(frames1_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic int ref_argmax(input frame_t d);
        int b = 0;
        for (int i = 1; i < 10; i++)
            if ($signed(d[i]) > $signed(d[b])) b = i;
        return b;
    endfunction

    // Offers a frame, then waits for the result; returns with valid_o up.
    task automatic send(input frame_t d, input bit keep_valid,
                        output int ycyc, output int lat,
                        output int cls, output logic [15:0] sc);
        int n = 0;
        data_i  = d;
        valid_i = 1'b1;
        #1;
        while (!yumi_o && n < 50) begin
            tick();
            n++;
        end
        chk("yumi_seen", yumi_o, 1'b1);
        ycyc = cyc;
        tick();
        data_i = {10{16'h7FFF}};
        if (!keep_valid) valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 50) begin
            tick();
            lat++;
        end
        cls = class_o;
        sc  = score_o;
    endtask

    vec_t vecs[7];

    initial begin
        int ycyc, lat, cls, prev;
        logic [15:0] sc;
        bit saw;
        frame_t d;

        vecs[0] = '{{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                     16'h0000, 16'h0005, 16'hFFFD, 16'h0005, 16'h0001},
                    1, 16'h0005};
        vecs[1] = '{{10{16'h8000}}, 0, 16'h8000};
        vecs[2] = '{{16'h7FFF, {9{16'h8000}}}, 9, 16'h7FFF};
        vecs[3] = '{{16'hFFFF, 16'hFFFF, 16'h0000, {7{16'hFFFF}}},
                    7, 16'h0000};
        vecs[4] = '{{10{16'h1234}}, 0, 16'h1234};
        vecs[5] = '{{{9{16'h7FFE}}, 16'h7FFF}, 0, 16'h7FFF};
        vecs[6] = '{{{4{16'h8001}}, 16'h0001, 16'h8000, {4{16'h8001}}},
                    5, 16'h0001};

        reset_i  = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        data_i   = '0;
        data1_i  = '0;
        valid1_i = 1'b0;
        ready1_i = 1'b1;
        tick();
        valid_i = 1'b1;
        #1;
        chk("yumi_in_reset", yumi_o, 1'b0);
        tick();
        valid_i = 1'b0;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_class", class_o, 4'd0);
        chk("rst_score", score_o, 16'd0);
        chk("rst_frames", frames_o, 8'd0);
        reset_i = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].data, 1'b0, ycyc, lat, cls, sc);
            chk($sformatf("v%0d_latency", i), lat, 10);
            chk($sformatf("v%0d_class", i), cls, vecs[i].exp_class);
            chk($sformatf("v%0d_score", i), sc, vecs[i].exp_score);
            tick();
            chk($sformatf("v%0d_frames", i), frames_o, i + 1);
        end

        ready_i = 1'b0;
        send(vecs[3].data, 1'b0, ycyc, lat, cls, sc);
        chk("hold_class", cls, 7);
        for (int i = 0; i < 20; i++) begin
            valid_i = $urandom_range(0, 1);
            for (int k = 0; k < 10; k++) data_i[k] = 16'($urandom);
            #1;
            chk($sformatf("hold_%0d", i),
                {valid_o, yumi_o, class_o, score_o},
                {1'b1, 1'b0, 4'd7, 16'h0000});
            tick();
        end
        ready_i = 1'b1;
        valid_i = 1'b1;
        #1;
        chk("bubble_yumi", yumi_o, 1'b0);
        tick();
        chk("hold_frames", frames_o, 8'd8);
        chk("idle_valid", valid_o, 1'b0);
        chk("idle_yumi", yumi_o, 1'b1);
        send(vecs[5].data, 1'b0, ycyc, lat, cls, sc);
        chk("after_hold_class", cls, 0);
        tick();
        chk("after_hold_frames", frames_o, 8'd9);

        data_i  = vecs[0].data;
        valid_i = 1'b1;
        #1;
        chk("abort_yumi", yumi_o, 1'b1);
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        chk("abort_outs", {valid_o, yumi_o, class_o, score_o, frames_o},
            '0);
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            saw |= valid_o;
        end
        chk("abort_no_result", saw, 1'b0);
        send(vecs[2].data, 1'b0, ycyc, lat, cls, sc);
        chk("post_abort_lat", lat, 10);
        chk("post_abort_class", cls, 9);
        tick();
        chk("post_abort_frames", frames_o, 8'd1);

        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        prev = 0;
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 10; k++) d[k] = 16'($urandom);
            if (f % 16 == 3) d[8] = d[2];
            send(d, 1'b1, ycyc, lat, cls, sc);
            if (f > 0) chk($sformatf("period_%0d", f), ycyc - prev, 11);
            prev = ycyc;
            chk($sformatf("b2b_class_%0d", f), cls, ref_argmax(d));
            chk($sformatf("b2b_score_%0d", f), sc, d[ref_argmax(d)]);
            tick();
            if (f == 254) chk("frames_255", frames_o, 8'd255);
        end
        valid_i = 1'b0;
        chk("frames_wrap", frames_o, 8'd0);

        data1_i[0] = 16'hFFF0;
        valid1_i   = 1'b1;
        #1;
        chk("n1_yumi", yumi1_o, 1'b1);
        tick();
        valid1_i = 1'b0;
        data1_i  = '0;
        chk("n1_valid", valid1_o, 1'b1);
        chk("n1_class", class1_o, 1'b0);
        chk("n1_score", score1_o, 16'hFFF0);
        tick();
        chk("n1_frames", frames1_o, 8'd1);
        chk("n1_idle", valid1_o, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
